simon_round_controller: RTL and testbench
=========================================

# simon_round_controller

Round-sequencing FSM for the Simon game. Requests one new colour per round from the LFSR random generator, appends its one-hot code to the stored sequence, and has the colour player replay the sequence. It then checks the player's button presses against the sequence and reports score, win and lose. It sits in `simon_game` between `random_generator`, `colours_player` and the button inputs.

## Interface
Parameters:
- `MAX_LEN`, 10 — rounds needed to win; range 1..15.
- `TIMEOUT_CYCLES`, 150000000 — idle cycles allowed per expected press (3 s at 50 MHz).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a new game; honoured only in IDLE, WIN or LOSE.
- `rand_colour`  in  3  current LFSR value.
- `btn`  in  5  debounced one-hot button press pulses, one cycle per press; bit order {orange, green, red, yellow, blue}.
- `doneplaying`  in  1  from player; high once the replay has finished.
- `generate_new`  out  1  one-cycle request to advance the LFSR.
- `play`  out  1  held high while a replay is requested.
- `num_colours_generated`  out  4  current sequence length.
- `colours_generated`  out  5*MAX_LEN  sequence store; slot i is bits [5i+4:5i].
- `score`  out  4  number of rounds completed.
- `busy`  out  1  high in every state except IDLE, WIN and LOSE.
- `win`  out  1  high while in WIN.
- `lose`  out  1  high while in LOSE.

## Operation
States are IDLE, GEN, LATCH, PLAY, INPUT, WIN and LOSE. All outputs are registered (Moore).

- **Reset:** state goes to IDLE. Every output, the sequence store, the press index and the timer are 0.
- **IDLE / WIN / LOSE:**
  - On `start`, clear the store, `num_colours_generated` and `score`, then go to GEN.
  - WIN and LOSE otherwise hold, keeping `score` and the store visible.
  - `btn` is ignored.
- **GEN:** `generate_new` = 1 for exactly this cycle; go to LATCH.
- **LATCH:**
  - `rand_colour` now holds the advanced value. Decode it and write it to slot `num_colours_generated`:
    - 000→00001, 001→00010, 010→00100, 011→01000
    - 100→10000, 101→01000, 110→00100, 111→00010
  - Increment `num_colours_generated`, then go to PLAY.
- **PLAY:**
  - `play` = 1 every cycle in this state.
  - When `doneplaying` = 1 is sampled, go to INPUT with index = 0 and timer = 0. `play` drops on entry to INPUT.
- **INPUT:**
  - **No press** (`btn` == 0): timer += 1. If timer == `TIMEOUT_CYCLES`-1, go to LOSE.
  - **Any press** (`btn` != 0): compare the whole 5-bit vector with slot[index].
    - **Exact match:** timer = 0 and index += 1. If index+1 == `num_colours_generated`, the round is complete:
      - `score` = `num_colours_generated`.
      - If `num_colours_generated` == `MAX_LEN`, go to WIN; otherwise go to GEN.
    - **Mismatch** (including multiple bits set): go to LOSE; `score` is unchanged.
- **Store:** slots at or beyond `num_colours_generated` stay 0. `num_colours_generated` never exceeds `MAX_LEN`.
- **Ignored inputs:** `start` is ignored while `busy` = 1. `btn` is ignored outside INPUT, including presses made during PLAY.

## Timing
- With `start` high in cycle N (IDLE): `generate_new` is high in N+1, the slot is written at the end of N+2, and `play` rises in N+3.
- With `doneplaying` sampled high in cycle M: `play` = 0 from M+1, and the first press is accepted from M+1.
- A completing correct press in cycle K gives:
  - `score` updated in K+1;
  - `generate_new` in K+1 for a non-final round;
  - `win` in K+1 for the final round.
- A wrong press in K gives `lose` = 1 in K+1.
- On timeout, `lose` = 1 exactly `TIMEOUT_CYCLES` cycles after INPUT entry or after the last accepted press.
- `rst` asserted in any cycle gives IDLE and all outputs 0 on the next edge; a game in progress is abandoned.
- `rst` and `start` high in the same cycle: reset wins.

## Test plan
- **Reset mid-play:** reset, `start`, then `rst` during PLAY → `play`, `busy`, `num_colours_generated` and `colours_generated` all 0 in the next cycle.
- **First round:** `start` with LFSR advancing to 011 → slot0 = 01000, `num_colours_generated` = 1, `play` high 3 cycles after `start`. Press `btn` = 01000 after `doneplaying` → `score` = 1, `generate_new` pulses.
- **Wrong press:** in round 2 (slots 01000, 00100), press 01000 then 00010 → `lose` = 1, `score` = 1.
- **Full game:** `MAX_LEN` = 3, answer every round correctly → `win` = 1 and `score` = 3 after the final press; `busy` = 0. A following `start` clears the store.
- **Timeout:** `TIMEOUT_CYCLES` = 8, no press after `doneplaying` → `lose` exactly 8 cycles after INPUT entry.
- **Invalid presses:** `btn` = 00011 when 00001 is expected → `lose`. Presses during PLAY and `start` while busy → ignored, with index and state unchanged.

Source files
------------

// File: rtl/simon_round_controller.sv
// simon_round_controller
// Round sequencer for the Simon game: grows the colour sequence by one entry
// per round, asks the player block to replay it, then checks the button
// presses against the stored sequence and reports score / win / lose.
module simon_round_controller #(
  parameter int MAX_LEN        = 10,
  parameter int TIMEOUT_CYCLES = 150000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           rand_colour,
  input  logic [4:0]           btn,
  input  logic                 doneplaying,
  output logic                 generate_new,
  output logic                 play,
  output logic [3:0]           num_colours_generated,
  output logic [5*MAX_LEN-1:0] colours_generated,
  output logic [3:0]           score,
  output logic                 busy,
  output logic                 win,
  output logic                 lose
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_LATCH,
    S_PLAY,
    S_INPUT,
    S_WIN,
    S_LOSE
  } state_t;

  localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  LEN_MAX    = 4'(MAX_LEN);

  state_t      state_q;
  logic [3:0]  num_q;
  logic [3:0]  score_q;
  logic [3:0]  idx_q;
  logic [31:0] timer_q;
  logic        gen_q;
  logic        play_q;
  logic        busy_q;
  logic        win_q;
  logic        lose_q;

  logic        store_clear_d;
  logic        store_write_d;
  logic [4:0]  new_code_d;
  logic [4:0]  exp_slot_d;
  logic [3:0]  idx_next_d;

  // LFSR value to one-hot colour; upper codes fold back onto the four lower
  // colours so every 3-bit value maps to a legal button.
  function automatic logic [4:0] decode_colour(input logic [2:0] c);
    logic [4:0] code;
    case (c)
      3'b000:  code = 5'b00001;
      3'b001:  code = 5'b00010;
      3'b010:  code = 5'b00100;
      3'b011:  code = 5'b01000;
      3'b100:  code = 5'b10000;
      3'b101:  code = 5'b01000;
      3'b110:  code = 5'b00100;
      default: code = 5'b00010;
    endcase
    return code;
  endfunction

  // Store control and lookup of the slot the player must press next.
  always_comb begin
    store_clear_d = start && ((state_q == S_IDLE) || (state_q == S_WIN) ||
                              (state_q == S_LOSE));
    store_write_d = (state_q == S_LATCH);
    new_code_d    = decode_colour(rand_colour);
    idx_next_d    = idx_q + 4'd1;
    exp_slot_d    = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (idx_q == 4'(i)) begin
        exp_slot_d = colours_generated[5*i +: 5];
      end
    end
  end

  // One register per sequence slot; a slot is written only when it is the
  // next free position, so slots beyond the current length remain zero.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_slot
    logic [4:0] slot_q;

    // Slot storage: cleared by reset or a new game, loaded in LATCH.
    always_ff @(posedge clk) begin
      if (rst || store_clear_d) begin
        slot_q <= '0;
      end else if (store_write_d && (num_q == 4'(gi))) begin
        slot_q <= new_code_d;
      end
    end

    assign colours_generated[5*gi +: 5] = slot_q;
  end

  // Round FSM with all status outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      score_q <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      gen_q   <= 1'b0;
      play_q  <= 1'b0;
      busy_q  <= 1'b0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      gen_q <= 1'b0;
      case (state_q)
        S_IDLE, S_WIN, S_LOSE: begin
          if (start) begin
            num_q   <= '0;
            score_q <= '0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
            busy_q  <= 1'b1;
            gen_q   <= 1'b1;
            state_q <= S_GEN;
          end
        end
        S_GEN: begin
          state_q <= S_LATCH;
        end
        S_LATCH: begin
          num_q   <= num_q + 4'd1;
          play_q  <= 1'b1;
          state_q <= S_PLAY;
        end
        S_PLAY: begin
          if (doneplaying) begin
            play_q  <= 1'b0;
            idx_q   <= '0;
            timer_q <= '0;
            state_q <= S_INPUT;
          end
        end
        S_INPUT: begin
          if (btn == 5'b00000) begin
            timer_q <= timer_q + 32'd1;
            if (timer_q == TIMER_LAST) begin
              lose_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_LOSE;
            end
          end else if (btn == exp_slot_d) begin
            timer_q <= '0;
            idx_q   <= idx_next_d;
            if (idx_next_d == num_q) begin
              score_q <= num_q;
              if (num_q == LEN_MAX) begin
                win_q   <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_WIN;
              end else begin
                gen_q   <= 1'b1;
                state_q <= S_GEN;
              end
            end
          end else begin
            // Wrong colour or several buttons at once: game over.
            lose_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_LOSE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign generate_new          = gen_q;
  assign play                  = play_q;
  assign num_colours_generated = num_q;
  assign score                 = score_q;
  assign busy                  = busy_q;
  assign win                   = win_q;
  assign lose                  = lose_q;

endmodule

// File: tb/tb_simon_round_controller.sv
// Scoreboard bench for simon_round_controller: stimulus pushes the expected
// output events (generate_new, play rise, win rise, lose rise) with their
// cycle stamps; a negedge monitor pops and compares each event it observes.
module tb_simon_round_controller;

  localparam int MAX_LEN = 3;
  localparam int TMO     = 8;

  localparam int EV_GEN  = 0;
  localparam int EV_PLAY = 1;
  localparam int EV_WIN  = 2;
  localparam int EV_LOSE = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [2:0]           rand_colour = 3'b000;
  logic [4:0]           btn = 5'b00000;
  logic                 doneplaying = 1'b0;
  logic                 generate_new;
  logic                 play;
  logic [3:0]           num_colours_generated;
  logic [5*MAX_LEN-1:0] colours_generated;
  logic [3:0]           score;
  logic                 busy;
  logic                 win;
  logic                 lose;

  simon_round_controller #(
    .MAX_LEN(MAX_LEN),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .rand_colour(rand_colour),
    .btn(btn),
    .doneplaying(doneplaying),
    .generate_new(generate_new),
    .play(play),
    .num_colours_generated(num_colours_generated),
    .colours_generated(colours_generated),
    .score(score),
    .busy(busy),
    .win(win),
    .lose(lose)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    int          at;
    logic [3:0]  score;
    logic [3:0]  num;
    logic [14:0] col;
    logic        busy;
  } ev_t;

  ev_t q[$];
  int  n_checks = 0;
  int  n_err = 0;

  // Bench-side view of the game: hand-chosen codes are written here.
  logic [4:0] exp_col[3];
  int         exp_num = 0;
  int         exp_score = 0;
  int         idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind  = kind;
    e.at    = at;
    e.score = 4'(exp_score);
    e.num   = 4'(exp_num);
    e.col   = {exp_col[2], exp_col[1], exp_col[0]};
    e.busy  = (kind == EV_GEN) || (kind == EV_PLAY);
    q.push_back(e);
  endtask

  task automatic handle_event(input int kind);
    ev_t e;
    if (q.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", kind, cyc);
    end else begin
      e = q.pop_front();
      $display("event kind=%0d cycle=%0d score=%0d num=%0d colours=%b busy=%0b",
               kind, cyc, score, num_colours_generated, colours_generated, busy);
      check("event_kind", 32'(kind), 32'(e.kind));
      check("event_cycle", 32'(cyc), 32'(e.at));
      check("event_score", 32'(score), 32'(e.score));
      check("event_num", 32'(num_colours_generated), 32'(e.num));
      check("event_colours", 32'(colours_generated), 32'(e.col));
      check("event_busy", 32'(busy), 32'(e.busy));
    end
  endtask

  // Monitor: detect DUT output events away from the active edge.
  logic play_prev = 1'b0;
  logic win_prev = 1'b0;
  logic lose_prev = 1'b0;
  always @(negedge clk) begin
    if (generate_new) handle_event(EV_GEN);
    if (play && !play_prev) handle_event(EV_PLAY);
    if (win && !win_prev) handle_event(EV_WIN);
    if (lose && !lose_prev) handle_event(EV_LOSE);
    play_prev <= play;
    win_prev  <= win;
    lose_prev <= lose;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called in IDLE/WIN/LOSE; returns in the GEN cycle.
  task automatic start_game;
    start = 1'b1;
    for (int i = 0; i < 3; i++) exp_col[i] = 5'b00000;
    exp_num   = 0;
    exp_score = 0;
    push(EV_GEN, cyc + 1);
    $display("start at cycle %0d", cyc);
    tick;
    start = 1'b0;
  endtask

  // Called in the GEN cycle; returns in the first PLAY cycle.
  task automatic gen_round(input logic [2:0] rnd, input logic [4:0] code);
    rand_colour = ~rnd;
    tick;
    rand_colour = rnd;
    exp_col[exp_num] = code;
    exp_num++;
    push(EV_PLAY, cyc + 1);
    $display("latch rand=%b expect code=%b at cycle %0d", rnd, code, cyc);
    tick;
    idx = 0;
  endtask

  // Stays in PLAY for nwait cycles (junk presses and a start pulse that must
  // be ignored), then signals doneplaying; returns in the INPUT entry cycle.
  task automatic finish_play(input int nwait, input logic [4:0] junk);
    for (int i = 0; i < nwait; i++) begin
      btn   = junk;
      start = (i == 0);
      tick;
    end
    btn         = 5'b00000;
    start       = 1'b0;
    doneplaying = 1'b1;
    tick;
    doneplaying = 1'b0;
  endtask

  task automatic press(input logic [4:0] code);
    btn = code;
    if (code == exp_col[idx]) begin
      idx++;
      if (idx == exp_num) begin
        exp_score = exp_num;
        if (exp_num == MAX_LEN) push(EV_WIN, cyc + 1);
        else push(EV_GEN, cyc + 1);
      end
    end else begin
      push(EV_LOSE, cyc + 1);
    end
    $display("press btn=%b at cycle %0d", code, cyc);
    tick;
    btn = 5'b00000;
  endtask

  task automatic idle(input int n, input logic pulse_start);
    for (int i = 0; i < n; i++) begin
      start = pulse_start && (i == 0);
      tick;
    end
    start = 1'b0;
  endtask

  initial begin
    // Reset state.
    tick;
    tick;
    check("rst_generate_new", 32'(generate_new), 32'd0);
    check("rst_play", 32'(play), 32'd0);
    check("rst_num", 32'(num_colours_generated), 32'd0);
    check("rst_colours", 32'(colours_generated), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_win", 32'(win), 32'd0);
    check("rst_lose", 32'(lose), 32'd0);
    rst = 1'b0;
    tick;

    // Reset during PLAY abandons the game.
    start_game;
    gen_round(3'b011, 5'b01000);
    rst = 1'b1;
    tick;
    check("midrst_play", 32'(play), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_num", 32'(num_colours_generated), 32'd0);
    check("midrst_colours", 32'(colours_generated), 32'd0);
    // Reset and start together: reset wins.
    start = 1'b1;
    tick;
    start = 1'b0;
    check("rststart_busy", 32'(busy), 32'd0);
    check("rststart_gen", 32'(generate_new), 32'd0);
    rst = 1'b0;
    tick;
    check("rststart_gen_after", 32'(generate_new), 32'd0);
    check("rststart_busy_after", 32'(busy), 32'd0);

    // Game A: first round, then a wrong press in round 2.
    start_game;
    gen_round(3'b011, 5'b01000);
    finish_play(3, 5'b01000);
    press(5'b01000);
    gen_round(3'b110, 5'b00100);
    finish_play(2, 5'b10000);
    press(5'b01000);
    press(5'b00010);
    btn = 5'b01000;
    tick;
    btn = 5'b00000;
    tick;

    // Game B: full game to WIN, with pauses and a start pulse while busy.
    start_game;
    gen_round(3'b000, 5'b00001);
    finish_play(1, 5'b00000);
    press(5'b00001);
    gen_round(3'b101, 5'b01000);
    finish_play(0, 5'b00000);
    press(5'b00001);
    idle(3, 1'b1);
    press(5'b01000);
    gen_round(3'b100, 5'b10000);
    finish_play(2, 5'b00001);
    press(5'b00001);
    idle(5, 1'b0);
    press(5'b01000);
    idle(5, 1'b1);
    press(5'b10000);
    btn = 5'b00001;
    tick;
    btn = 5'b00000;
    tick;

    // Game C: new start clears the store; no press leads to timeout.
    start_game;
    gen_round(3'b111, 5'b00010);
    finish_play(1, 5'b00000);
    push(EV_LOSE, cyc + TMO);
    idle(TMO + 2, 1'b0);

    // Game D: two buttons at once when a single colour is expected.
    start_game;
    gen_round(3'b000, 5'b00001);
    finish_play(0, 5'b00000);
    press(5'b00011);
    idle(3, 1'b0);

    check("queue_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
